// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS-I instruction and its forwarded operands into an ALU bundle,
// registered behind a valid/ready handshake with a one-entry skid buffer so in_ready is a flop.
module alu_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] store_data,
  output logic [4:0]        dest_reg,
  output logic              reg_write,
  output logic              illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOR  = 4'h6,
    OP_UCMP = 4'h7,
    OP_SCMP = 4'h8,
    OP_SLL  = 4'h9,
    OP_SRL  = 4'hA,
    OP_SRA  = 4'hB,
    OP_GTZ  = 4'hC
  } alu_op_e;

  typedef struct packed {
    alu_op_e           aluOp;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] storeData;
    logic [4:0]        dest;
    logic              regWrite;
    logic              illegal;
  } bundle_t;

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_simm;
  logic [DATA_W-1:0] w_zimm;
  logic [DATA_W-1:0] w_shamt;
  logic              w_unused;
  bundle_t           w_dec;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rt     = instr[20:16];
  assign w_rd     = instr[15:11];
  assign w_simm   = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign w_zimm   = {{(DATA_W-16){1'b0}}, instr[15:0]};
  assign w_shamt  = {{(DATA_W-5){1'b0}}, instr[10:6]};
  // The rs index itself is irrelevant here; its value arrives already forwarded on rs_data.
  assign w_unused = ^instr[25:21];

  always_comb begin
    w_dec           = '0;
    w_dec.aluOp     = OP_ADD;
    unique case (w_opcode)
      6'h00: begin
        w_dec.in1      = rs_data;
        w_dec.in2      = rt_data;
        w_dec.dest     = w_rd;
        w_dec.regWrite = (w_rd != 5'd0);
        unique case (w_funct)
          6'h20, 6'h21: w_dec.aluOp = OP_ADD;
          6'h22, 6'h23: w_dec.aluOp = OP_SUB;
          6'h24:        w_dec.aluOp = OP_AND;
          6'h25:        w_dec.aluOp = OP_OR;
          6'h26:        w_dec.aluOp = OP_XOR;
          6'h27:        w_dec.aluOp = OP_NOR;
          6'h2A:        w_dec.aluOp = OP_SCMP;
          6'h2B:        w_dec.aluOp = OP_UCMP;
          6'h00: begin w_dec.aluOp = OP_SLL; w_dec.in1 = w_shamt; end
          6'h02: begin w_dec.aluOp = OP_SRL; w_dec.in1 = w_shamt; end
          6'h03: begin w_dec.aluOp = OP_SRA; w_dec.in1 = w_shamt; end
          6'h04:        w_dec.aluOp = OP_SLL;
          6'h06:        w_dec.aluOp = OP_SRL;
          6'h07:        w_dec.aluOp = OP_SRA;
          default: begin
            w_dec          = '0;
            w_dec.aluOp    = OP_ADD;
            w_dec.illegal  = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09: begin
        w_dec.in1 = rs_data; w_dec.in2 = w_simm;
        w_dec.dest = w_rt; w_dec.regWrite = (w_rt != 5'd0);
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_dec.aluOp = (w_opcode == 6'h0C) ? OP_AND : (w_opcode == 6'h0D) ? OP_OR : OP_XOR;
        w_dec.in1 = rs_data; w_dec.in2 = w_zimm;
        w_dec.dest = w_rt; w_dec.regWrite = (w_rt != 5'd0);
      end
      6'h0A, 6'h0B: begin
        w_dec.aluOp = (w_opcode == 6'h0A) ? OP_SCMP : OP_UCMP;
        w_dec.in1 = rs_data; w_dec.in2 = w_simm;
        w_dec.dest = w_rt; w_dec.regWrite = (w_rt != 5'd0);
      end
      6'h0F: begin
        w_dec.aluOp = OP_SLL;
        w_dec.in1 = DATA_W'(16); w_dec.in2 = w_zimm;
        w_dec.dest = w_rt; w_dec.regWrite = (w_rt != 5'd0);
      end
      6'h23: begin
        w_dec.in1 = rs_data; w_dec.in2 = w_simm;
        w_dec.dest = w_rt; w_dec.regWrite = (w_rt != 5'd0);
      end
      6'h2B: begin
        w_dec.in1 = rs_data; w_dec.in2 = w_simm;
        w_dec.storeData = rt_data;
      end
      6'h04, 6'h05: begin
        w_dec.aluOp = OP_SUB;
        w_dec.in1 = rs_data; w_dec.in2 = rt_data;
      end
      6'h07: begin
        w_dec.aluOp = OP_GTZ;
        w_dec.in1 = rs_data;
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  bundle_t r_main;
  bundle_t r_skid;
  logic    r_mainValid;
  logic    r_skidValid;
  logic    r_inReady;
  logic    w_inXfer;
  logic    w_drain;

  assign w_inXfer = in_valid & r_inReady;
  assign w_drain  = r_mainValid & out_ready;

  // Skid only fills while main is stalled; it always refills main before new input is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main      <= '0;
      r_skid      <= '0;
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
    end else if (flush) begin
      r_main      <= '0;
      r_skid      <= '0;
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
    end else if (!r_mainValid || w_drain) begin
      if (r_skidValid) begin
        r_main      <= r_skid;
        r_mainValid <= 1'b1;
        r_skidValid <= 1'b0;
        r_inReady   <= 1'b1;
      end else if (w_inXfer) begin
        r_main      <= w_dec;
        r_mainValid <= 1'b1;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_inXfer) begin
      r_skid      <= w_dec;
      r_skidValid <= 1'b1;
      r_inReady   <= 1'b0;
    end
  end

  assign in_ready   = r_inReady;
  assign out_valid  = r_mainValid;
  assign alu_op     = r_main.aluOp;
  assign alu_in1    = r_main.in1;
  assign alu_in2    = r_main.in2;
  assign store_data = r_main.storeData;
  assign dest_reg   = r_main.dest;
  assign reg_write  = r_main.regWrite;
  assign illegal    = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage: decode vectors at full throughput, then
// hand-written backpressure, flush and asynchronous-reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .store_data(store_data),
    .dest_reg(dest_reg), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  dest;
    logic        rw;
    logic        ill;
    logic        chkStore;
    logic [31:0] store;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mkVec(logic [31:0] i, logic [31:0] rs, logic [31:0] rt,
                                 logic [3:0] op, logic [31:0] in1, logic [31:0] in2,
                                 logic [4:0] dest, logic rw, logic ill,
                                 logic chk, logic [31:0] st);
    vec_t v;
    v.instr = i; v.rs = rs; v.rt = rt; v.op = op; v.in1 = in1; v.in2 = in2;
    v.dest = dest; v.rw = rw; v.ill = ill; v.chkStore = chk; v.store = st;
    return v;
  endfunction

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] rs,
                               input logic [31:0] rt, input logic v, input logic ordy,
                               input logic fl);
    @(negedge clk);
    instr = i; rs_data = rs; rt_data = rt;
    in_valid = v; out_ready = ordy; flush = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sampleAfterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mkVec(32'h2065FFFC, 32'd10, 32'd0, 4'h0, 32'd10, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[1]  = mkVec(32'h000410C3, 32'd7, 32'h80000000, 4'hB, 32'd3, 32'h80000000, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[2]  = mkVec(32'h3C011234, 32'h55, 32'd0, 4'h9, 32'd16, 32'h00001234, 5'd1, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[3]  = mkVec(32'hFC000000, 32'h11, 32'h22, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    vecs[4]  = mkVec(32'hAC450008, 32'h100, 32'hDEAD, 4'h0, 32'h100, 32'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD);
    vecs[5]  = mkVec(32'h00221822, 32'd50, 32'd8, 4'h1, 32'd50, 32'd8, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[6]  = mkVec(32'h00220020, 32'd50, 32'd8, 4'h0, 32'd50, 32'd8, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[7]  = mkVec(32'h0022202A, 32'd50, 32'd8, 4'h8, 32'd50, 32'd8, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[8]  = mkVec(32'h0022202B, 32'd50, 32'd8, 4'h7, 32'd50, 32'd8, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[9]  = mkVec(32'h00222027, 32'd50, 32'd8, 4'h6, 32'd50, 32'd8, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[10] = mkVec(32'h00222006, 32'd5, 32'hF0, 4'hA, 32'd5, 32'hF0, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[11] = mkVec(32'h30268001, 32'd50, 32'd8, 4'h3, 32'd50, 32'h00008001, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[12] = mkVec(32'h2826FFFF, 32'd50, 32'd8, 4'h8, 32'd50, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[13] = mkVec(32'h2C26FFFF, 32'd50, 32'd8, 4'h7, 32'd50, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[14] = mkVec(32'h10220010, 32'd50, 32'd8, 4'h1, 32'd50, 32'd8, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[15] = mkVec(32'h1C200005, 32'd50, 32'd8, 4'hC, 32'd50, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[16] = mkVec(32'h00221801, 32'd50, 32'd8, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    vecs[17] = mkVec(32'h3827F0F0, 32'd50, 32'd8, 4'h5, 32'd50, 32'h0000F0F0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[18] = mkVec(32'h8C28FFF8, 32'd50, 32'd8, 4'h0, 32'd50, 32'hFFFFFFF8, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset.alu_in2",   alu_in2,        32'd0);
    checkOutput("reset.dest_reg",  32'(dest_reg),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back decode vectors with out_ready held high: one result per cycle.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].rs, vecs[i].rt, 1'b1, 1'b1, 1'b0);
      sampleAfterEdge();
      checkOutput($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("v%0d.alu_op", i),    32'(alu_op),    32'(vecs[i].op));
      checkOutput($sformatf("v%0d.alu_in1", i),   alu_in1,        vecs[i].in1);
      checkOutput($sformatf("v%0d.alu_in2", i),   alu_in2,        vecs[i].in2);
      checkOutput($sformatf("v%0d.dest_reg", i),  32'(dest_reg),  32'(vecs[i].dest));
      checkOutput($sformatf("v%0d.reg_write", i), 32'(reg_write), 32'(vecs[i].rw));
      checkOutput($sformatf("v%0d.illegal", i),   32'(illegal),   32'(vecs[i].ill));
      if (vecs[i].chkStore)
        checkOutput($sformatf("v%0d.store_data", i), store_data, vecs[i].store);
    end
    applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    sampleAfterEdge();
    checkOutput("idle.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: three bundles (dest 1,2,3) against a stalled consumer.
    applyStimulus(32'h20010001, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("bp.first.dest", 32'(dest_reg), 32'd1);
    checkOutput("bp.first.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(32'h20020002, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("bp.second.in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp.second.held_dest", 32'(dest_reg), 32'd1);
    applyStimulus(32'h20030003, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("bp.third.held_dest", 32'(dest_reg), 32'd1);
    checkOutput("bp.third.held_in2", alu_in2, 32'd1);
    checkOutput("bp.third.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(32'h20030003, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    sampleAfterEdge();
    checkOutput("bp.drain1.dest", 32'(dest_reg), 32'd2);
    checkOutput("bp.drain1.in_ready", 32'(in_ready), 32'd1);
    sampleAfterEdge();
    checkOutput("bp.drain2.dest", 32'(dest_reg), 32'd3);
    checkOutput("bp.drain2.out_valid", 32'(out_valid), 32'd1);
    applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    sampleAfterEdge();
    checkOutput("bp.empty.out_valid", 32'(out_valid), 32'd0);

    // Flush with main and skid both occupied, plus a dropped input in the flush cycle.
    applyStimulus(32'h20040004, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    sampleAfterEdge();
    applyStimulus(32'h20050005, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("fl.full.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(32'h20060006, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    sampleAfterEdge();
    checkOutput("fl.out_valid", 32'(out_valid), 32'd0);
    checkOutput("fl.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sampleAfterEdge();
      checkOutput($sformatf("fl.after%0d.out_valid", k), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    applyStimulus(32'h20070007, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    sampleAfterEdge();
    applyStimulus(32'h20080008, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("ar.pre.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar.out_valid", 32'(out_valid), 32'd0);
    checkOutput("ar.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sampleAfterEdge();
      checkOutput($sformatf("ar.after%0d.out_valid", k), 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that produces the operand/opcode bundle consumed by the single-cycle ALU.
- Decodes a MIPS-I instruction plus register-file read data into alu_op, alu_in1, alu_in2, destination and write-enable.
- Registers that bundle behind a valid/ready handshake with a one-entry skid buffer, so in_ready is a register output.
- Supports pipeline flush from branch resolution.

Parameters:
- DATA_W, 32, operand width (fixed ALU width; other values unsupported)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode-side bundle valid
- in_ready  out  1  stage can accept a bundle; registered
- instr  in  32  instruction word
- rs_data  in  32  forwarded value of register rs
- rt_data  in  32  forwarded value of register rt
- flush  in  1  discard all held bundles this cycle
- out_valid  out  1  ALU bundle valid
- out_ready  in  1  EX stage accepts bundle
- alu_op  out  4  ALU opcode
- alu_in1  out  32  ALU operand 1; shift amount in bits 4:0 for shifts
- alu_in2  out  32  ALU operand 2; value shifted for shifts
- store_data  out  32  rt_data passed through for sw
- dest_reg  out  5  writeback register index
- reg_write  out  1  writeback enable
- illegal  out  1  unrecognised opcode/funct

Behaviour:
- Clock and reset: clk, rst_n. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, in_ready=1, skid empty, all data outputs 0.
- Opcodes: add=0, sub=1, and=3, or=4, xor=5, nor=6, ucmp=7, scmp=8, sll=9, srl=A, sra=B, gtz=C.
- simm = sign-extended instr[15:0]; zimm = zero-extended instr[15:0]; shamt = instr[10:6] zero-extended.
- R-type (op=00), dest = rd, reg_write = (rd != 0):
  - funct 20/21 add: in1=rs, in2=rt.
  - funct 22/23 sub.
  - funct 24 and; 25 or; 26 xor; 27 nor.
  - funct 2A scmp; 2B ucmp.
  - funct 00/02/03 sll/srl/sra: in1=shamt, in2=rt.
  - funct 04/06/07 sllv/srlv/srav: in1=rs, in2=rt.
- I-type, dest = rt, reg_write = (rt != 0):
  - op 08/09 add simm.
  - op 0C/0D/0E and/or/xor zimm.
  - op 0A scmp simm; 0B ucmp simm.
  - op 0F lui: sll with in1=16, in2=zimm.
  - op 23 lw: add simm.
- No-writeback ops (reg_write=0, dest=0):
  - op 2B sw: add simm, store_data=rt.
  - op 04/05 beq/bne: sub rs,rt.
  - op 07 bgtz: gtz, in1=rs, in2=0.
- Anything else: illegal=1, alu_op=add, operands 0, reg_write=0.
- Decode is combinational on the input; the result is captured into the main register or the skid register.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Outputs are held stable while out_valid & !out_ready.
  - Main empty, or draining this cycle: the accepted bundle goes to main. Latency is 1 cycle, so a bundle accepted at edge N is visible from N.
  - Main full and not draining: the accepted bundle goes to skid, and in_ready drops next cycle.
  - When main drains and skid is full: skid moves to main, skid empties, and in_ready rises next cycle.
  - Full throughput (one bundle per cycle) whenever out_ready is held high.
- Flush: synchronous, priority over everything.
  - Main and skid are cleared; out_valid=0 and in_ready=1 next cycle.
  - An input presented in the flush cycle is dropped.
- rst_n assertion mid-transfer clears state immediately, independent of clk.

Test Plan:
- Reset with rst_n=0 mid-stream → out_valid=0 and in_ready=1 asynchronously; no bundle emitted after release until new input.
- addi $5,$3,-4 (0x2065FFFC), rs_data=10, out_ready=1 → next cycle alu_op=0, in1=10, in2=0xFFFFFFFC, dest=5, reg_write=1.
- sra $2,$4,3 (0x000410C3), rt_data=0x80000000 → alu_op=B, in1=3, in2=0x80000000, dest=2. lui $1,0x1234 → alu_op=9, in1=16, in2=0x00001234.
- out_ready held 0, issue 3 back-to-back bundles → first two accepted, in_ready=0 after the second, third held; release out_ready → order 1,2,3 preserved, no loss or duplication.
- flush while main and skid are full → out_valid=0 and in_ready=1 next cycle; neither bundle ever appears.
- op=0x3F → illegal=1, reg_write=0. sw (0xAC450008), rt_data=0xDEAD → alu_op=0, in2=8, store_data=0xDEAD, reg_write=0.
